// File: rtl/irq_controller.sv
// irq_controller: synchronizes, captures, masks and prioritizes device IRQ lines into one registered request.
// Ports: CLK_I clock, RST_I async active-low reset, ADD_I[7:2] word address (ADD_I[4:2] selects the register),
//        WE_I/DAT_I register write, DAT_O combinational read data, IRQ_I device lines,
//        HWINT_O registered PEND & MASK gated by GIE, INT_O registered OR of HWINT_O.
// Register map: 0 PEND (W1C), 1 MASK, 2 TYPE (1 = rising edge), 3 CTRL (bit0 GIE), 4 ACTIVE, 5 RAW.
// Optional: define IRQC_SYNC2_EN to add a second synchronizer flop for asynchronous sources.
module irq_controller #(
    parameter int NUM_SRC = 6
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [7:2]         ADD_I,
    input  logic               WE_I,
    input  logic [31:0]        DAT_I,
    output logic [31:0]        DAT_O,
    input  logic [NUM_SRC-1:0] IRQ_I,
    output logic [NUM_SRC-1:0] HWINT_O,
    output logic               INT_O
);
    logic [NUM_SRC-1:0] irq_s, irq_p, pend, mask, typ, pm, wdat, clr;
    logic               gie;
    logic [2:0]         sel, idx;
    logic               unused;

    assign sel    = ADD_I[4:2];
    assign wdat   = DAT_I[NUM_SRC-1:0];
    assign clr    = (WE_I && sel == 3'd0) ? wdat : '0;
    assign pm     = pend & mask;
    assign unused = ^{ADD_I[7:5], DAT_I[31:NUM_SRC]};

`ifdef IRQC_SYNC2_EN
    logic [NUM_SRC-1:0] irq_m;
    always_ff @(posedge CLK_I or negedge RST_I)
        if (!RST_I) irq_m <= '0;
        else irq_m <= IRQ_I;
`else
    logic [NUM_SRC-1:0] irq_m;
    assign irq_m = IRQ_I;
`endif

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            irq_s   <= '0;
            irq_p   <= '0;
            pend    <= '0;
            mask    <= '0;
            typ     <= '0;
            gie     <= 1'b0;
            HWINT_O <= '0;
            INT_O   <= 1'b0;
        end else begin
            irq_s   <= irq_m;
            irq_p   <= irq_s;
            // edge sources latch until W1C (set wins); level sources mirror the synchronized line
            pend    <= (typ & ((irq_s & ~irq_p) | (pend & ~clr))) | (~typ & irq_s);
            mask    <= (WE_I && sel == 3'd1) ? wdat : mask;
            typ     <= (WE_I && sel == 3'd2) ? wdat : typ;
            gie     <= (WE_I && sel == 3'd3) ? DAT_I[0] : gie;
            HWINT_O <= gie ? pm : '0;
            INT_O   <= gie & |pm;
        end
    end

    // scan high to low so the lowest set index wins
    always_comb begin
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pm[i]) idx = i[2:0];
    end

    always_comb
        DAT_O = sel == 3'd0 ? 32'(pend) :
                sel == 3'd1 ? 32'(mask) :
                sel == 3'd2 ? 32'(typ) :
                sel == 3'd3 ? {31'd0, gie} :
                sel == 3'd4 ? {|pm, 28'd0, idx} :
                sel == 3'd5 ? 32'(irq_s) : 32'd0;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller.
module tb_irq_controller;
    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [7:2]  ADD_I = '0;
    logic        WE_I  = 1'b0;
    logic [31:0] DAT_I = '0;
    logic [31:0] DAT_O;
    logic [5:0]  IRQ_I = '0;
    logic [5:0]  HWINT_O;
    logic        INT_O;
    int          n_chk = 0;
    int          n_fail = 0;
    int          hi_cnt;

`ifdef IRQC_SYNC2_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    irq_controller #(.NUM_SRC(6)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADD_I(ADD_I), .WE_I(WE_I), .DAT_I(DAT_I),
        .DAT_O(DAT_O), .IRQ_I(IRQ_I), .HWINT_O(HWINT_O), .INT_O(INT_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        ADD_I = {3'b000, a};
        DAT_I = d;
        WE_I  = 1'b1;
        tick();
        WE_I  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        ADD_I = {3'b000, a};
        #1;
        check(tag, DAT_O, exp);
    endtask

    initial begin
        #1 RST_I = 1'b0;
        #1;
        check("rst_int", {31'd0, INT_O}, 32'd0);
        check("rst_hwint", {26'd0, HWINT_O}, 32'd0);
        rd("rst_pend", 3'd0, 32'd0);
        rd("rst_ctrl", 3'd3, 32'd0);
        tick();
        RST_I = 1'b1;
        tick();
        wr(3'd2, 32'h3F);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd3, 32'h1);
        rd("mask_upper", 3'd1, 32'h3F);
        wr(3'd6, 32'hFFFF_FFFF);
        rd("reg6_zero", 3'd6, 32'd0);

        // edge latency: rise captured at edge k, PEND at k+1, INT_O at k+2
        IRQ_I = 6'h01;
        tick();
        repeat (LAT) tick();
        rd("edge_pend_early", 3'd0, 32'd0);
        tick();
        rd("edge_pend", 3'd0, 32'h1);
        check("edge_int_early", {31'd0, INT_O}, 32'd0);
        tick();
        check("edge_int", {31'd0, INT_O}, 32'd1);
        check("edge_hwint", {26'd0, HWINT_O}, 32'h1);
        rd("raw", 3'd5, 32'h1);
        wr(3'd0, 32'h1);
        tick();
        check("w1c_int", {31'd0, INT_O}, 32'd0);
        repeat (3) tick();
        check("held_int", {31'd0, INT_O}, 32'd0);
        rd("held_pend", 3'd0, 32'd0);
        IRQ_I = 6'h00;
        repeat (3) tick();

        // level tracking with a W1C during the pulse
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h04);
        repeat (3) tick();
        hi_cnt = 0;
        ADD_I = 6'd0;
        IRQ_I = 6'h04;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) IRQ_I = 6'h00;
            if (c == 1) begin WE_I = 1'b1; DAT_I = 32'h4; end
            tick();
            WE_I = 1'b0;
            if (INT_O) hi_cnt++;
            if (c == 2) check("lvl_pend_w1c", DAT_O, 32'h4);
            if (c == 4 + LAT) check("lvl_pend_drop", DAT_O, 32'h0);
        end
        check("lvl_int_cycles", hi_cnt, 32'd3);

        // priority: lowest pending index reported
        wr(3'd2, 32'h3F);
        wr(3'd1, 32'h3F);
        IRQ_I = 6'h28;
        repeat (2 + LAT) tick();
        rd("active_3", 3'd4, 32'h8000_0003);
        wr(3'd0, 32'h08);
        rd("active_5", 3'd4, 32'h8000_0005);
        IRQ_I = 6'h00;
        wr(3'd0, 32'h20);
        rd("active_none", 3'd4, 32'h0);
        tick();

        // simultaneous set/clear with source 1 masked
        wr(3'd1, 32'h3D);
        IRQ_I = 6'h02;
        tick();
        repeat (LAT) tick();
        wr(3'd0, 32'h02);
        rd("setclr_pend", 3'd0, 32'h02);
        tick();
        check("masked_hwint", {26'd0, HWINT_O}, 32'h0);
        check("masked_int", {31'd0, INT_O}, 32'd0);
        wr(3'd1, 32'h3F);
        tick();
        check("unmask_int", {31'd0, INT_O}, 32'd1);
        check("unmask_hwint", {26'd0, HWINT_O}, 32'h02);

        // GIE gating
        wr(3'd3, 32'h0);
        tick();
        check("gie0_int", {31'd0, INT_O}, 32'd0);
        rd("ctrl0", 3'd3, 32'h0);
        wr(3'd3, 32'hFFFF_FFFF);
        tick();
        check("gie1_int", {31'd0, INT_O}, 32'd1);
        rd("ctrl1", 3'd3, 32'h1);

        // async reset mid-run with every source pending
        IRQ_I = 6'h3F;
        repeat (3 + LAT) tick();
        rd("all_pend", 3'd0, 32'h3F);
        check("all_int", {31'd0, INT_O}, 32'd1);
        #1 RST_I = 1'b0;
        #1;
        check("mid_rst_int", {31'd0, INT_O}, 32'd0);
        check("mid_rst_hwint", {26'd0, HWINT_O}, 32'h0);
        rd("mid_rst_pend", 3'd0, 32'd0);
        rd("mid_rst_mask", 3'd1, 32'd0);
        rd("mid_rst_type", 3'd2, 32'd0);
        rd("mid_rst_ctrl", 3'd3, 32'd0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt aggregation peripheral directly downstream of the timer and other bus devices.
- Consumes the device IRQ lines: it synchronizes and captures each line as edge or level, then masks it and prioritizes it.
- Drives a single registered interrupt request, plus the masked pending vector for the CPU's CP0 Cause.IP[7:2].
- Register access uses the same word-addressed device bus as the timer.

Parameters:
- NUM_SRC, 6: number of interrupt sources (1..8); source 0 is the highest priority.

Ports:
- CLK_I  input  1  system clock, all state on rising edge
- RST_I  input  1  asynchronous, active-low reset
- ADD_I  input  6 [7:2]  word address; ADD_I[4:2] selects the register
- WE_I  input  1  write strobe, write takes effect at the clock edge
- DAT_I  input  32  write data
- DAT_O  output  32  read data, combinational from ADD_I
- IRQ_I  input  NUM_SRC  device interrupt lines, active-high (bit 0 = timer)
- HWINT_O  output  NUM_SRC  registered PEND & MASK, gated by GIE
- INT_O  output  1  registered OR of HWINT_O

Behaviour:
- Reset (RST_I low, any time, including mid-capture):
  - PEND, MASK, TYPE, GIE, all synchronizer and edge flops, HWINT_O and INT_O clear to 0 immediately.
  - DAT_O follows the cleared registers.
- Register map (ADD_I[4:2]). Bits above NUM_SRC-1 read 0 and ignore writes.
  - 0 PEND: R; write-1-to-clear.
  - 1 MASK: RW; 1 = enabled.
  - 2 TYPE: RW; 1 = rising-edge, 0 = level.
  - 3 CTRL: RW; bit0 = GIE; other bits read 0.
  - 4 ACTIVE: RO. bit31 = 1 if any (PEND & MASK) bit set. bits[2:0] = lowest index set in PEND & MASK, or 0 if none.
  - 5 RAW: RO; synchronized lines irq_s.
  - 6, 7: read 0; writes ignored.
- Input stage: irq_s <= IRQ_I each edge (one flop). irq_p <= irq_s each edge (edge-detect history).
- Pending update, per bit i, each edge:
  - Level (TYPE[i]=0): PEND[i] <= irq_s[i]. A W1C write has no effect, because the device must drop its line.
  - Edge (TYPE[i]=1): set = irq_s[i] & ~irq_p[i]; clr = WE_I & (ADD_I[4:2]==0) & DAT_I[i]. PEND[i] <= set | (PEND[i] & ~clr). A simultaneous set and clear leaves the bit set.
  - Masked sources still update PEND.
- TYPE change: the new type applies from the next edge. Switching to edge keeps current PEND until cleared; switching to level makes PEND track irq_s.
- Outputs: on each edge, HWINT_O <= GIE ? (PEND & MASK) : 0 and INT_O <= |(PEND & MASK) & GIE. Both use the pre-edge PEND values.
- Latency from an IRQ_I rise captured at edge k:
  - irq_s set at k
  - PEND set at k+1
  - HWINT_O and INT_O set at k+2
- Deassert latency: a W1C or MASK/GIE write at edge k drops INT_O at edge k+1.
- DAT_O is a pure mux of current register state. No read side effects.

Optional Feature:
- Macro IRQC_SYNC2_EN.
- Defined: a second synchronizer flop is inserted before irq_s, for asynchronous external sources. All IRQ_I-to-PEND/INT_O latencies grow by one cycle (PEND at k+2, INT_O at k+3). RAW reports the second-stage value.
- Undefined: single flop as described above.

Test Plan:
- Reset: drive RST_I=0 mid-run with PEND=6'h3F -> INT_O=0, HWINT_O=0, and reads of PEND/MASK/TYPE/CTRL all return 0, with no clock edge needed.
- Edge latency: TYPE=1, MASK=1, GIE=1; IRQ_I[0] high at edge 10 and held -> PEND=1 after edge 11, INT_O=1 after edge 12. Write PEND=1 at edge 20 -> INT_O=0 after edge 21, and it stays 0 while IRQ_I[0] remains high.
- Level tracking: TYPE=0, MASK=6'h04, GIE=1; IRQ_I[2] pulsed for 3 cycles -> PEND[2] follows one cycle behind, and INT_O is high for exactly 3 cycles. A W1C during the pulse has no effect.
- Priority: edge mode, sources 5 and 3 fire together with MASK=6'h3F -> ACTIVE reads 32'h8000_0003. After PEND bit 3 is cleared, ACTIVE reads 32'h8000_0005.
- Simultaneous set/clear plus masking: a W1C of bit 1 on the same edge as a new rising edge on source 1 -> PEND[1]=1. With MASK[1]=0 -> HWINT_O[1]=0 and INT_O=0. Then set MASK[1]=1 -> INT_O=1 next edge.
- GIE gating: with PEND & MASK nonzero and GIE=0 -> INT_O=0. Write CTRL=1 -> INT_O=1 after one edge. With IRQC_SYNC2_EN defined, repeat the edge-latency test -> INT_O is set after edge 13.
